tmr_scrub_ctrl: RTL and testbench



---
 rtl/tmr_scrub_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_tmr_scrub_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_scrub_ctrl.sv
// Triple-redundant register bank with host read/write access, a background
// majority-vote scrubber that repairs disagreeing copies, and a fault-injection port.
module tmr_scrub_ctrl #(
  parameter int WIDTH     = 8,
  parameter int NWORDS    = 16,
  parameter int AW        = 4,
  parameter int SCRUB_DIV = 4,
  parameter int CNT_W     = 8
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             WE,
  input  logic [AW-1:0]    WADDR,
  input  logic [WIDTH-1:0] WDATA,
  input  logic             RE,
  input  logic [AW-1:0]    RADDR,
  output logic [WIDTH-1:0] RDATA,
  output logic             RVALID,
  input  logic             SCRUB_EN,
  input  logic             INJ_EN,
  input  logic [1:0]       INJ_SEL,
  input  logic [AW-1:0]    INJ_ADDR,
  input  logic [WIDTH-1:0] INJ_MASK,
  output logic             SCRUB_BUSY,
  output logic             ERR_FLAG,
  output logic [AW-1:0]    ERR_ADDR,
  output logic [CNT_W-1:0] ERR_CNT
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_VOTE, S_FIX} state_t;

  localparam int DIV_W = (SCRUB_DIV > 1) ? $clog2(SCRUB_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCRUB_DIV - 1);

  function automatic logic [WIDTH-1:0] maj3(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic [WIDTH-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [NWORDS-1:0][WIDTH-1:0] mem_a_q, mem_a_d;
  logic [NWORDS-1:0][WIDTH-1:0] mem_b_q, mem_b_d;
  logic [NWORDS-1:0][WIDTH-1:0] mem_c_q, mem_c_d;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [AW-1:0]    scrub_addr_q, scrub_addr_d;
  logic [WIDTH-1:0] lat_a_q, lat_a_d, lat_b_q, lat_b_d, lat_c_q, lat_c_d;
  logic [WIDTH-1:0] vote_q, vote_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             err_flag_q, err_flag_d;
  logic [AW-1:0]    err_addr_q, err_addr_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic             host_hit;
  logic             fix_commit;
  logic [WIDTH-1:0] voted;
  logic             mismatch;

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    scrub_addr_d = scrub_addr_q;
    lat_a_d      = lat_a_q;
    lat_b_d      = lat_b_q;
    lat_c_d      = lat_c_q;
    vote_d       = vote_q;
    rdata_d      = rdata_q;
    rvalid_d     = RE;
    err_flag_d   = 1'b0;
    err_addr_d   = err_addr_q;
    err_cnt_d    = err_cnt_q;
    fix_commit   = 1'b0;

    // A host write to the word under scrub always wins and restarts that word.
    host_hit = WE && (WADDR == scrub_addr_q);
    voted    = maj3(lat_a_q, lat_b_q, lat_c_q);
    mismatch = (lat_a_q != voted) || (lat_b_q != voted) || (lat_c_q != voted);

    if (RE) begin
      rdata_d = maj3(mem_a_q[RADDR], mem_b_q[RADDR], mem_c_q[RADDR]);
    end

    unique case (state_q)
      S_IDLE: begin
        if (SCRUB_EN) begin
          if (div_q == DIV_LAST) begin
            div_d   = '0;
            state_d = S_FETCH;
          end else begin
            div_d = div_q + 1'b1;
          end
        end
      end
      S_FETCH: begin
        lat_a_d = mem_a_q[scrub_addr_q];
        lat_b_d = mem_b_q[scrub_addr_q];
        lat_c_d = mem_c_q[scrub_addr_q];
        state_d = host_hit ? S_IDLE : S_VOTE;
      end
      S_VOTE: begin
        state_d = S_IDLE;
        if (!host_hit) begin
          if (mismatch) begin
            vote_d  = voted;
            state_d = S_FIX;
          end else begin
            scrub_addr_d = scrub_addr_q + 1'b1;
          end
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!host_hit) begin
          fix_commit   = 1'b1;
          err_flag_d   = 1'b1;
          err_addr_d   = scrub_addr_q;
          err_cnt_d    = sat_inc(err_cnt_q);
          scrub_addr_d = scrub_addr_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    mem_a_d = mem_a_q;
    mem_b_d = mem_b_q;
    mem_c_d = mem_c_q;
    if (fix_commit) begin
      mem_a_d[scrub_addr_q] = vote_q;
      mem_b_d[scrub_addr_q] = vote_q;
      mem_c_d[scrub_addr_q] = vote_q;
    end
    if (WE) begin
      mem_a_d[WADDR] = WDATA;
      mem_b_d[WADDR] = WDATA;
      mem_c_d[WADDR] = WDATA;
    end
    // Injection is applied on top of any same-cycle write to the same word.
    if (INJ_EN) begin
      case (INJ_SEL)
        2'd0:    mem_a_d[INJ_ADDR] = mem_a_d[INJ_ADDR] ^ INJ_MASK;
        2'd1:    mem_b_d[INJ_ADDR] = mem_b_d[INJ_ADDR] ^ INJ_MASK;
        2'd2:    mem_c_d[INJ_ADDR] = mem_c_d[INJ_ADDR] ^ INJ_MASK;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (R) begin
      mem_a_q      <= '0;
      mem_b_q      <= '0;
      mem_c_q      <= '0;
      state_q      <= S_IDLE;
      div_q        <= '0;
      scrub_addr_q <= '0;
      lat_a_q      <= '0;
      lat_b_q      <= '0;
      lat_c_q      <= '0;
      vote_q       <= '0;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
      err_flag_q   <= 1'b0;
      err_addr_q   <= '0;
      err_cnt_q    <= '0;
    end else begin
      mem_a_q      <= mem_a_d;
      mem_b_q      <= mem_b_d;
      mem_c_q      <= mem_c_d;
      state_q      <= state_d;
      div_q        <= div_d;
      scrub_addr_q <= scrub_addr_d;
      lat_a_q      <= lat_a_d;
      lat_b_q      <= lat_b_d;
      lat_c_q      <= lat_c_d;
      vote_q       <= vote_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
      err_flag_q   <= err_flag_d;
      err_addr_q   <= err_addr_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign RDATA      = rdata_q;
  assign RVALID     = rvalid_q;
  assign SCRUB_BUSY = (state_q != S_IDLE);
  assign ERR_FLAG   = err_flag_q;
  assign ERR_ADDR   = err_addr_q;
  assign ERR_CNT    = err_cnt_q;

endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// Bench for tmr_scrub_ctrl: a three-copy storage model drives expected read data
// and expected correction events into queues that a negedge monitor drains.
module tb_tmr_scrub_ctrl;
  localparam int WIDTH = 8, NWORDS = 16, AW = 4, SCRUB_DIV = 4, CNT_W = 8;

  logic CLK = 1'b0, R = 1'b1;
  logic WE = 1'b0, RE = 1'b0, SCRUB_EN = 1'b0, INJ_EN = 1'b0;
  logic [AW-1:0] WADDR = '0, RADDR = '0, INJ_ADDR = '0;
  logic [WIDTH-1:0] WDATA = '0, INJ_MASK = '0;
  logic [1:0] INJ_SEL = '0;
  logic [WIDTH-1:0] RDATA;
  logic RVALID, SCRUB_BUSY, ERR_FLAG;
  logic [AW-1:0] ERR_ADDR;
  logic [CNT_W-1:0] ERR_CNT;

  tmr_scrub_ctrl #(.WIDTH(WIDTH), .NWORDS(NWORDS), .AW(AW), .SCRUB_DIV(SCRUB_DIV), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .R(R), .WE(WE), .WADDR(WADDR), .WDATA(WDATA), .RE(RE), .RADDR(RADDR),
    .RDATA(RDATA), .RVALID(RVALID), .SCRUB_EN(SCRUB_EN), .INJ_EN(INJ_EN), .INJ_SEL(INJ_SEL),
    .INJ_ADDR(INJ_ADDR), .INJ_MASK(INJ_MASK), .SCRUB_BUSY(SCRUB_BUSY), .ERR_FLAG(ERR_FLAG),
    .ERR_ADDR(ERR_ADDR), .ERR_CNT(ERR_CNT));

  always #5 CLK = ~CLK;

  int total = 0, bad = 0;
  logic [WIDTH-1:0] cp [3][NWORDS];
  int ptr_m = 0, cnt_m = 0;
  logic [WIDTH-1:0] rd_q [$];
  int err_addr_q [$];
  int err_cnt_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] vote(input int a);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      int ones;
      ones = int'(cp[0][a][i]) + int'(cp[1][a][i]) + int'(cp[2][a][i]);
      r[i] = (ones >= 2);
    end
    return r;
  endfunction

  // One host cycle, issued at a negedge; the model is updated in the order
  // the storage sees it: read old value, then write, then injection on top.
  task automatic step(input bit we, input int wa, input logic [WIDTH-1:0] wd,
                      input bit re, input int ra,
                      input bit inj, input int sel, input int ia, input logic [WIDTH-1:0] mk);
    WE = we; WADDR = AW'(wa); WDATA = wd;
    RE = re; RADDR = AW'(ra);
    INJ_EN = inj; INJ_SEL = 2'(sel); INJ_ADDR = AW'(ia); INJ_MASK = mk;
    if (re) rd_q.push_back(vote(ra));
    if (we) for (int k = 0; k < 3; k++) cp[k][wa] = wd;
    if (inj && sel < 3) cp[sel][ia] = cp[sel][ia] ^ mk;
    @(negedge CLK);
    WE = 1'b0; RE = 1'b0; INJ_EN = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic count_falls(input int n);
    int falls = 0;
    int budget = n * (SCRUB_DIV + 4) + 20;
    bit prev = SCRUB_BUSY;
    while (falls < n && budget > 0) begin
      @(negedge CLK);
      if (prev && !SCRUB_BUSY) falls++;
      prev = SCRUB_BUSY;
      budget--;
    end
    check("scrub_steps", falls, n);
  endtask

  task automatic wait_busy(input string name);
    int budget = SCRUB_DIV + 8;
    while (!SCRUB_BUSY && budget > 0) begin
      @(negedge CLK);
      budget--;
    end
    check(name, SCRUB_BUSY, 1);
  endtask

  task automatic run_steps(input int n);
    SCRUB_EN = 1'b1;
    count_falls(n);
    SCRUB_EN = 1'b0;
  endtask

  // A full pass visits every word once starting at the scrub pointer, so the
  // pointer ends where it began; each inconsistent word yields one correction.
  task automatic full_pass();
    for (int i = 0; i < NWORDS; i++) begin
      int a;
      logic [WIDTH-1:0] v;
      a = (ptr_m + i) % NWORDS;
      v = vote(a);
      if (cp[0][a] != v || cp[1][a] != v || cp[2][a] != v) begin
        for (int k = 0; k < 3; k++) cp[k][a] = v;
        cnt_m = (cnt_m >= (1 << CNT_W) - 1) ? cnt_m : cnt_m + 1;
        err_addr_q.push_back(a);
        err_cnt_q.push_back(cnt_m);
      end
    end
    run_steps(NWORDS);
    idle(2);
    check("err_events_drained", err_addr_q.size(), 0);
    check("err_cnt_after_pass", ERR_CNT, cnt_m);
  endtask

  task automatic read_all();
    for (int a = 0; a < NWORDS; a++) step(0, 0, 0, 1, a, 0, 0, 0, 0);
    idle(2);
    check("reads_drained", rd_q.size(), 0);
  endtask

  always @(negedge CLK) begin
    if (!R) begin
      if (RVALID) begin
        if (rd_q.size() == 0) check("unexpected_rvalid", RVALID, 0);
        else check("rdata", RDATA, rd_q.pop_front());
      end
      if (ERR_FLAG) begin
        if (err_addr_q.size() == 0) check("unexpected_err_flag", ERR_FLAG, 0);
        else begin
          check("err_addr", ERR_ADDR, err_addr_q.pop_front());
          check("err_cnt", ERR_CNT, err_cnt_q.pop_front());
        end
      end
    end
  end

  initial begin
    int c0;
    for (int k = 0; k < 3; k++) for (int a = 0; a < NWORDS; a++) cp[k][a] = '0;
    idle(3);
    R = 1'b0;
    check("rst_rdata", RDATA, 0);
    check("rst_rvalid", RVALID, 0);
    check("rst_busy", SCRUB_BUSY, 0);
    check("rst_err_flag", ERR_FLAG, 0);
    check("rst_err_addr", ERR_ADDR, 0);
    check("rst_err_cnt", ERR_CNT, 0);

    // Basic write/read, then same-cycle write+read returns the old value.
    step(1, 3, 8'hA5, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 3, 0, 0, 0, 0);
    step(1, 3, 8'h11, 1, 3, 0, 0, 0, 0);
    step(0, 0, 0, 1, 3, 0, 0, 0, 0);
    idle(2);
    check("t1_err_cnt", ERR_CNT, 0);

    // Host write during VOTE of addr 2 aborts that step; the rescrub is clean.
    step(0, 0, 0, 0, 0, 1, 1, 2, 8'h5A);
    SCRUB_EN = 1'b1;
    count_falls(2);
    wait_busy("abort_fetch_seen");
    @(negedge CLK);
    step(1, 2, 8'h77, 0, 0, 0, 0, 0, 0);
    count_falls(1);
    SCRUB_EN = 1'b0;
    ptr_m = 3;
    idle(2);
    check("abort_err_cnt", ERR_CNT, 0);
    step(0, 0, 0, 1, 2, 0, 0, 0, 0);
    idle(2);

    // Single-copy corruption is masked on read and repaired exactly once.
    step(1, 5, 8'h3C, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 5, 8'hFF);
    step(0, 0, 0, 1, 5, 0, 0, 0, 0);
    full_pass();
    check("t2_err_cnt", ERR_CNT, 1);
    full_pass();

    // Two different copies corrupted in different bits: one correction.
    c0 = cnt_m;
    step(0, 0, 0, 0, 0, 1, 0, 7, 8'h01);
    step(0, 0, 0, 0, 0, 1, 2, 7, 8'h02);
    full_pass();
    check("t3_err_cnt", ERR_CNT, c0 + 1);
    step(0, 0, 0, 1, 7, 0, 0, 0, 0);
    step(1, 9, 8'h40, 0, 0, 1, 2, 9, 8'h0F);
    step(0, 0, 0, 1, 9, 0, 0, 0, 0);
    full_pass();

    // Randomized host/injection traffic, then scrub and read everything back.
    for (int r = 0; r < 3; r++) begin
      repeat (40) begin
        step($urandom_range(0, 1), $urandom_range(0, NWORDS - 1), 8'($urandom),
             $urandom_range(0, 1), $urandom_range(0, NWORDS - 1),
             ($urandom_range(0, 2) == 0), $urandom_range(0, 3),
             $urandom_range(0, NWORDS - 1), 8'($urandom));
      end
      idle(2);
      full_pass();
      read_all();
    end

    // Drive the correction counter into saturation.
    for (int p = 0; p < 17; p++) begin
      for (int a = 0; a < NWORDS; a++)
        step(0, 0, 0, 0, 0, 1, $urandom_range(0, 2), a, 8'($urandom_range(1, 255)));
      full_pass();
    end
    check("sat_err_cnt", ERR_CNT, 8'hFF);

    // Reset while the scrubber sits in FIX.
    step(0, 0, 0, 0, 0, 1, 0, ptr_m, 8'h80);
    SCRUB_EN = 1'b1;
    wait_busy("fix_fetch_seen");
    @(negedge CLK);
    @(negedge CLK);
    R = 1'b1;
    SCRUB_EN = 1'b0;
    @(negedge CLK);
    R = 1'b0;
    check("fixrst_rdata", RDATA, 0);
    check("fixrst_rvalid", RVALID, 0);
    check("fixrst_busy", SCRUB_BUSY, 0);
    check("fixrst_err_flag", ERR_FLAG, 0);
    check("fixrst_err_addr", ERR_ADDR, 0);
    check("fixrst_err_cnt", ERR_CNT, 0);
    for (int k = 0; k < 3; k++) for (int a = 0; a < NWORDS; a++) cp[k][a] = '0;
    ptr_m = 0;
    cnt_m = 0;
    read_all();
    full_pass();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
